// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, LSB-first payload,
// optional odd/even parity, one or two stop bits, valid/ready intake.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_ser,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST =
    BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t                state;
  logic [BAUD_W-1:0]     baud;
  logic [3:0]            bit_cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic                  baud_end;

  assign baud_end = (baud == BAUD_LAST);
  assign o_ready  = (state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_ser   <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state != IDLE) begin
        baud <= baud_end ? '0 : baud + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            shreg   <= i_data;
            // Parity fixed at intake so later i_data changes cannot leak in
            par_bit <= (^i_data) ^ PAR_ODD;
            baud    <= '0;
            bit_cnt <= '0;
            o_ser   <= 1'b0;
            o_busy  <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          if (baud_end) begin
            o_ser <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (baud_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                o_ser <= par_bit;
                state <= PAR;
              end else begin
                o_ser <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
              o_ser   <= shreg[1];
            end
          end
        end
        PAR: begin
          if (baud_end) begin
            o_ser <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (baud_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three parameter sets share one clock,
// a selector routes stimulus to and observation from one instance.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data;
  logic       valid;
  int         sel;

  logic va, vb, vc;
  logic rdy_a, ser_a, busy_a, done_a;
  logic rdy_b, ser_b, busy_b, done_b;
  logic rdy_c, ser_c, busy_c, done_c;
  logic rdy, ser, busy, done;

  int passed = 0;
  int total  = 0;

  logic ser_log [0:255];
  int   busy_cnt;
  int   done_cnt;
  int   first_done;

  always #5 clk = ~clk;

  assign va = valid && (sel == 0);
  assign vb = valid && (sel == 1);
  assign vc = valid && (sel == 2);

  always_comb begin
    rdy  = rdy_a;
    ser  = ser_a;
    busy = busy_a;
    done = done_a;
    if (sel == 1) begin
      rdy = rdy_b; ser = ser_b; busy = busy_b; done = done_b;
    end else if (sel == 2) begin
      rdy = rdy_c; ser = ser_c; busy = busy_c; done = done_c;
    end
  end

  uart_tx_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)
  ) u_even (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(va),
    .o_ready(rdy_a), .o_ser(ser_a), .o_busy(busy_a), .o_done(done_a)
  );

  uart_tx_param #(
    .DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)
  ) u_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(vb),
    .o_ready(rdy_b), .o_ser(ser_b), .o_busy(busy_b), .o_done(done_b)
  );

  uart_tx_param #(
    .DATA_BITS(7), .CLKS_PER_BIT(3), .PARITY(0), .STOP_BITS(2)
  ) u_7b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data[6:0]), .i_valid(vc),
    .o_ready(rdy_c), .o_ser(ser_c), .o_busy(busy_c), .o_done(done_c)
  );

  // Present a payload and return 1ns after the accepting edge.
  task automatic accept(input logic [7:0] d, input bit keep);
    @(negedge clk);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) valid = 1'b0;
  endtask

  // Record the line for n cycles, optionally pulsing or dropping valid.
  task automatic capture(input int n, input int pulse_at,
                         input logic [7:0] pdata, input int drop_at);
    busy_cnt   = 0;
    done_cnt   = 0;
    first_done = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ser_log[k] = ser;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (pulse_at >= 0 && k == pulse_at) begin
        valid = 1'b1;
        data  = pdata;
      end else if (pulse_at >= 0 && k == pulse_at + 1) begin
        valid = 1'b0;
      end
      if (k == drop_at) valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    sel   = 0;
    valid = 1'b0;
    data  = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (ser !== 1'b1) $display("FAIL rst_ser: got %b want 1", ser);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else passed++;
    total++;
    if (rdy !== 1'b1) $display("FAIL rst_ready: got %b want 1", rdy);
    else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_even_frame;
    logic ef [0:10];
    logic got;
    bit   bad;
    ef = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    sel = 0;
    accept(8'h0B, 1'b0);
    data = 8'hFF;
    capture(50, -1, 8'h00, -1);
    for (int b = 0; b < 11; b++) begin
      bad = 0;
      got = ef[b];
      for (int s = 0; s < 4; s++)
        if (ser_log[b*4+s] !== ef[b]) begin
          bad = 1;
          got = ser_log[b*4+s];
        end
      total++;
      if (bad) $display("FAIL even_0b bit%0d: got %b want %b", b, got, ef[b]);
      else passed++;
    end
    total++;
    if (busy_cnt !== 44)
      $display("FAIL even_busy_len: got %0d want 44", busy_cnt);
    else passed++;
    total++;
    if (done_cnt !== 1)
      $display("FAIL even_done_cnt: got %0d want 1", done_cnt);
    else passed++;
    total++;
    if (first_done !== 44)
      $display("FAIL even_done_pos: got %0d want 44", first_done);
    else passed++;
  endtask

  task automatic test_odd_parity;
    logic [7:0] pay [0:1];
    logic got;
    bit   bad;
    pay = '{8'h00, 8'hFF};
    sel = 1;
    for (int t = 0; t < 2; t++) begin
      accept(pay[t], 1'b0);
      capture(48, -1, 8'h00, -1);
      bad = 0;
      got = 1'b1;
      for (int s = 0; s < 4; s++)
        if (ser_log[36+s] !== 1'b1) begin
          bad = 1;
          got = ser_log[36+s];
        end
      total++;
      if (bad) $display("FAIL odd_par_%0d: got %b want 1", t, got);
      else passed++;
      bad = 0;
      got = pay[t][0];
      for (int s = 4; s < 36; s++)
        if (ser_log[s] !== pay[t][0]) begin
          bad = 1;
          got = ser_log[s];
        end
      total++;
      if (bad) $display("FAIL odd_payload_%0d: got %b want %b", t, got, pay[t][0]);
      else passed++;
      total++;
      if (done_cnt !== 1)
        $display("FAIL odd_done_%0d: got %0d want 1", t, done_cnt);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic ea [0:10];
    logic eb [0:10];
    logic got;
    bit   bad;
    ea = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
           1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    eb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
           1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    sel = 0;
    accept(8'hA5, 1'b1);
    data = 8'h3C;
    capture(110, -1, 8'h00, 60);
    for (int b = 0; b < 11; b++) begin
      bad = 0;
      got = ea[b];
      for (int s = 0; s < 4; s++)
        if (ser_log[b*4+s] !== ea[b]) begin
          bad = 1;
          got = ser_log[b*4+s];
        end
      total++;
      if (bad) $display("FAIL b2b_a5 bit%0d: got %b want %b", b, got, ea[b]);
      else passed++;
      bad = 0;
      got = eb[b];
      for (int s = 0; s < 4; s++)
        if (ser_log[45+b*4+s] !== eb[b]) begin
          bad = 1;
          got = ser_log[45+b*4+s];
        end
      total++;
      if (bad) $display("FAIL b2b_3c bit%0d: got %b want %b", b, got, eb[b]);
      else passed++;
    end
    total++;
    if (ser_log[44] !== 1'b1)
      $display("FAIL b2b_gap: got %b want 1", ser_log[44]);
    else passed++;
    total++;
    if (done_cnt !== 2)
      $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt);
    else passed++;
    total++;
    if (busy_cnt !== 88)
      $display("FAIL b2b_busy_len: got %0d want 88", busy_cnt);
    else passed++;
  endtask

  task automatic test_ignore_busy;
    logic ef [0:10];
    logic got;
    bit   bad;
    ef = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sel = 0;
    accept(8'h0F, 1'b0);
    capture(70, 12, 8'h55, -1);
    for (int b = 0; b < 11; b++) begin
      bad = 0;
      got = ef[b];
      for (int s = 0; s < 4; s++)
        if (ser_log[b*4+s] !== ef[b]) begin
          bad = 1;
          got = ser_log[b*4+s];
        end
      total++;
      if (bad) $display("FAIL ign_0f bit%0d: got %b want %b", b, got, ef[b]);
      else passed++;
    end
    total++;
    if (done_cnt !== 1)
      $display("FAIL ign_done_cnt: got %0d want 1", done_cnt);
    else passed++;
    total++;
    if (busy_cnt !== 44)
      $display("FAIL ign_busy_len: got %0d want 44", busy_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_frame;
    logic ef [0:10];
    logic got;
    bit   bad;
    ef = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    sel = 0;
    accept(8'hFF, 1'b0);
    capture(18, -1, 8'h00, -1);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (ser !== 1'b1) $display("FAIL mid_rst_ser: got %b want 1", ser);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy);
    else passed++;
    total++;
    if (rdy !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", rdy);
    else passed++;
    capture(4, -1, 8'h00, -1);
    rst_n = 1'b1;
    capture(4, -1, 8'h00, -1);
    total++;
    if (done_cnt !== 0)
      $display("FAIL mid_rst_done: got %0d want 0", done_cnt);
    else passed++;
    accept(8'h81, 1'b0);
    capture(50, -1, 8'h00, -1);
    for (int b = 0; b < 11; b++) begin
      bad = 0;
      got = ef[b];
      for (int s = 0; s < 4; s++)
        if (ser_log[b*4+s] !== ef[b]) begin
          bad = 1;
          got = ser_log[b*4+s];
        end
      total++;
      if (bad) $display("FAIL post_rst_81 bit%0d: got %b want %b", b, got, ef[b]);
      else passed++;
    end
    total++;
    if (done_cnt !== 1)
      $display("FAIL post_rst_done: got %0d want 1", done_cnt);
    else passed++;
  endtask

  task automatic test_7bit_2stop;
    logic ef [0:9];
    logic got;
    bit   bad;
    ef = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1, 1'b1, 1'b1};
    sel = 2;
    accept(8'h41, 1'b0);
    capture(36, -1, 8'h00, -1);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      got = ef[b];
      for (int s = 0; s < 3; s++)
        if (ser_log[b*3+s] !== ef[b]) begin
          bad = 1;
          got = ser_log[b*3+s];
        end
      total++;
      if (bad) $display("FAIL b7_41 bit%0d: got %b want %b", b, got, ef[b]);
      else passed++;
    end
    total++;
    if (busy_cnt !== 30)
      $display("FAIL b7_busy_len: got %0d want 30", busy_cnt);
    else passed++;
    total++;
    if (first_done !== 30)
      $display("FAIL b7_done_pos: got %0d want 30", first_done);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_even_frame;
    test_odd_parity;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid_frame;
    test_7bit_2stop;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8: payload width per frame, legal range 5..9.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: i_clk cycles per serial bit, legal range >= 2.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_data, input, DATA_BITS bits: the payload, sampled only at acceptance.
REQ-008 The block SHALL have port i_valid, input, 1 bit: the payload request.
REQ-009 The block SHALL have port o_ready, output, 1 bit: high when a new payload can be accepted.
REQ-010 The block SHALL have port o_ser, output, 1 bit: the serial line, idle high.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high while a frame is on the line.
REQ-012 The block SHALL have port o_done, output, 1 bit: a one-cycle pulse at frame completion.

Function
REQ-013 The block SHALL implement states IDLE, START, DATA, PAR and STOP.
REQ-014 Acceptance SHALL occur on a rising edge where i_valid=1 and o_ready=1.
- At acceptance: latch i_data into a shift register, clear the bit and baud counters, enter START.
REQ-015 o_ready SHALL be 1 in IDLE and 0 in every other state.
- While not ready, i_valid SHALL be ignored; there is no queue.
REQ-016 Each serial bit SHALL be held on o_ser for exactly CLKS_PER_BIT cycles.
- A baud counter SHALL count 0..CLKS_PER_BIT-1 and advance the bit when it reaches terminal count.
REQ-017 Frame order SHALL be:
- start bit, 0;
- DATA_BITS payload bits, LSB first;
- parity bit, only if PARITY != 0;
- STOP_BITS stop bits, 1.
REQ-018 The parity bit SHALL be computed from the latched payload.
- Even: XOR of the payload bits.
- Odd: inverse of that XOR.
- Changes on i_data after acceptance SHALL NOT affect the frame.
REQ-019 Transitions SHALL be:
- START -> DATA;
- DATA -> PAR after the last payload bit if PARITY != 0, otherwise DATA -> STOP;
- PAR -> STOP;
- STOP -> IDLE after the final stop bit.
REQ-020 o_ser SHALL be registered; it changes to the start bit on the cycle after acceptance.
REQ-021 Frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles, where P = 1 if PARITY != 0, else 0.
REQ-022 o_busy SHALL be 1 from the first start-bit cycle through the last stop-bit cycle, and 0 otherwise.
REQ-023 o_done SHALL be 1 for exactly one cycle per frame: the first IDLE cycle after the last stop bit.
REQ-024 Back-to-back: if i_valid=1 during the o_done cycle, that payload SHALL be accepted.
- Its start bit then follows the previous stop bit with no gap beyond that one idle cycle.

Reset
REQ-025 While i_rst_n=0, the block SHALL immediately (asynchronously) force:
- state = IDLE; o_ser = 1; o_busy = 0; o_ready = 1; o_done = 0;
- counters and shift register = 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no o_done pulse.
- The first accepted frame after release SHALL be complete and correct.

Verification
REQ-027 The bench SHALL cover: DATA_BITS=8, CLKS_PER_BIT=4, PARITY=2, STOP_BITS=1; send 0x0B.
- o_ser bits 0,1,1,0,1,0,0,0,0,1(parity),1, each 4 cycles, 44 cycles total.
- o_busy high 44 cycles; one o_done pulse.
REQ-028 The bench SHALL cover: PARITY=1; send 0x00 -> parity bit 1. Send 0xFF -> parity bit 1.
REQ-029 The bench SHALL cover: i_valid held high with 0xA5 then 0x3C.
- Exactly two frames, LSB-first payloads 1,0,1,0,0,1,0,1 and 0,0,1,1,1,1,0,0.
- One IDLE cycle between them; o_done pulses twice.
REQ-030 The bench SHALL cover: i_valid pulsed with 0x55 during DATA of an active 0x0F frame.
- Ignored: exactly one frame, carrying 0x0F.
REQ-031 The bench SHALL cover: i_rst_n driven low during payload bit 3.
- o_ser=1, o_busy=0, o_ready=1 before the next clock edge; no o_done.
- After release, send 0x81 -> a correct frame.
REQ-032 The bench SHALL cover: DATA_BITS=7, PARITY=0, STOP_BITS=2, CLKS_PER_BIT=3; send 0x41.
- Frame 0,1,0,0,0,0,0,1,1,1; 30 cycles total.
